// File: rtl/cipher_pkg.sv
// Shared widths and the FIFO entry layout for the cipher nibble packer.
package cipher_pkg;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

  typedef struct packed {
    logic [BYTE_W-1:0] cipher;
    logic [BYTE_W-1:0] key;
    logic              padded;
  } entry_t;

endpackage

// File: rtl/nibble_fifo.sv
// First-word fall-through FIFO of packed cipher/key entries.
// A push into a full FIFO only lands if a pop frees a slot on the same edge.
module nibble_fifo
  import cipher_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LEVEL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               push_i,
  input  entry_t             pushData_i,
  input  logic               pop_i,
  output entry_t             popData_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LEVEL_W-1:0] level_o
);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               wrEn;
  logic               rdEn;

  assign full_o    = (level_q == LEVEL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign popData_o = mem_q[rdPtr_q];

  assign rdEn = pop_i & ~empty_o;
  assign wrEn = push_i & (~full_o | rdEn);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (wrEn) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (rdEn) rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({wrEn, rdEn})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the level counter gates visibility of every slot.
  always_ff @(posedge clock) begin
    if (wrEn) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/cipher_nibble_packer.sv
// Packs cipher/key nibble pairs into bytes and buffers them toward the link.
// Upstream cannot stall, so a drop on a full FIFO raises a sticky overflow.
module cipher_nibble_packer
  import cipher_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic [NIBBLE_W-1:0] encryptedData,
  input  logic [NIBBLE_W-1:0] privateKey,
  input  logic                dataValid,
  input  logic                flush,
  input  logic                clearOverflow,
  output logic [BYTE_W-1:0]   outCipher,
  output logic [BYTE_W-1:0]   outKey,
  output logic                outPadded,
  output logic                outValid,
  input  logic                outReady,
  output logic [LEVEL_W-1:0]  level,
  output logic                overflow
);

  logic                holdValid_q, holdValid_d;
  logic [NIBBLE_W-1:0] holdCipher_q, holdCipher_d;
  logic [NIBBLE_W-1:0] holdKey_q, holdKey_d;
  logic                overflow_q, overflow_d;
  logic                pushReq;
  entry_t              pushEntry;
  entry_t              headEntry;
  logic                fifoFull;
  logic                fifoEmpty;
  logic                popReq;
  logic                drop;

  // A completing nibble always wins over flush; flush only pads a lone nibble.
  always_comb begin
    holdValid_d      = holdValid_q;
    holdCipher_d     = holdCipher_q;
    holdKey_d        = holdKey_q;
    pushReq          = 1'b0;
    pushEntry        = '0;
    if (dataValid && holdValid_q) begin
      pushReq          = 1'b1;
      pushEntry.cipher = {holdCipher_q, encryptedData};
      pushEntry.key    = {holdKey_q, privateKey};
      pushEntry.padded = 1'b0;
      holdValid_d      = 1'b0;
    end else if (dataValid && flush) begin
      pushReq          = 1'b1;
      pushEntry.cipher = {encryptedData, {NIBBLE_W{1'b0}}};
      pushEntry.key    = {privateKey, {NIBBLE_W{1'b0}}};
      pushEntry.padded = 1'b1;
    end else if (dataValid) begin
      holdValid_d  = 1'b1;
      holdCipher_d = encryptedData;
      holdKey_d    = privateKey;
    end else if (flush && holdValid_q) begin
      pushReq          = 1'b1;
      pushEntry.cipher = {holdCipher_q, {NIBBLE_W{1'b0}}};
      pushEntry.key    = {holdKey_q, {NIBBLE_W{1'b0}}};
      pushEntry.padded = 1'b1;
      holdValid_d      = 1'b0;
    end
  end

  assign popReq = ~fifoEmpty & outReady;
  assign drop   = pushReq & fifoFull & ~popReq;

  always_comb begin
    overflow_d = overflow_q;
    if (drop)               overflow_d = 1'b1;
    else if (clearOverflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      holdValid_q  <= 1'b0;
      holdCipher_q <= '0;
      holdKey_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      holdValid_q  <= holdValid_d;
      holdCipher_q <= holdCipher_d;
      holdKey_q    <= holdKey_d;
      overflow_q   <= overflow_d;
    end
  end

  nibble_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clock     (clock),
    .resetN    (resetN),
    .push_i    (pushReq),
    .pushData_i(pushEntry),
    .pop_i     (popReq),
    .popData_o (headEntry),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty),
    .level_o   (level)
  );

  assign outValid  = ~fifoEmpty;
  assign outCipher = headEntry.cipher;
  assign outKey    = headEntry.key;
  assign outPadded = headEntry.padded;
  assign overflow  = overflow_q;

endmodule
